batch_feed_controller: RTL

- Sequences one aggregating pipeline by accepting batch requests (bot count per batch) and streaming upstream bots into the pipeline.
- Marks the final bot of each batch and obeys the pipeline's slowDownInput backpressure.
- Matches each returned pcoeffSum/pcoeffCount result against the expected bot count of the oldest outstanding batch.
- Sits between the job distributor and the pipeline; one instance per pipeline.

---
 rtl/batch_feed_controller_pkg.sv | 23 ++
 rtl/batch_feed_controller_expected_count_fifo.sv | 56 +++++
 rtl/batch_feed_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/batch_feed_controller_pkg.sv
// Shared widths, state type and helpers for the batch feed controller.
// PCOEFF_COUNT_BITWIDTH falls back to 16 when the pipeline globals header has not defined it.
`ifndef PCOEFF_COUNT_BITWIDTH
`define PCOEFF_COUNT_BITWIDTH 16
`endif

package batch_feed_controller_pkg;

  localparam int DEFAULT_COUNT_WIDTH = `PCOEFF_COUNT_BITWIDTH;
  localparam int BOT_WIDTH           = 128;
  localparam int SUM_EXTRA_BITS      = 35;

  // Encodings match the pipeline globals (IDLE = 0, FEED = 1).
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FEED = 1'b1
  } feedState_t;

  function automatic logic [31:0] satInc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/batch_feed_controller_expected_count_fifo.sv
// Synchronous FIFO holding the expected bot count of every batch still in flight.
// DEPTH must be a power of two, at least 2.
module expected_count_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign doPush    = push && !full;
  assign doPop     = pop && !empty;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rdPtr];
  assign occupancy = count;

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/batch_feed_controller.sv
// Feeds batches of bots into one aggregating pipeline and checks returned counts.
// Optional macro BATCH_FEED_PROFILE_EN enables stall/starve cycle counters.
module batch_feed_controller
  import batch_feed_controller_pkg::*;
#(
  parameter int COUNT_WIDTH     = DEFAULT_COUNT_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          batchReqValid,
  input  logic [COUNT_WIDTH-1:0]        batchReqBotCount,
  output logic                          batchReqReady,
  input  logic                          botInValid,
  input  logic [BOT_WIDTH-1:0]          botIn,
  output logic                          botInReady,
  output logic                          isBotValid,
  output logic [BOT_WIDTH-1:0]          bot,
  output logic                          lastBotOfBatch,
  input  logic                          slowDownInput,
  input  logic                          pipeResultsValid,
  input  logic [COUNT_WIDTH+34:0]       pipePcoeffSum,
  input  logic [COUNT_WIDTH-1:0]        pipePcoeffCount,
  input  logic                          pipeEccStatus,
  output logic                          resultValid,
  output logic [COUNT_WIDTH+34:0]       resultSum,
  output logic                          resultMismatch,
  output logic                          errorSticky,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic [31:0]                   stallCycles,
  output logic [31:0]                   starveCycles
);

  feedState_t             state;
  feedState_t             nextState;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   reqAccept, pushReq, zeroReq, transfer, lastTransfer;
  logic                   fifoFull, fifoEmpty, resultPop, headMismatch;
  logic [COUNT_WIDTH-1:0] fifoHead;
  logic                   illegalCount, unexpectedResult, countMismatch, eccSeen;
  logic                   illegalCountNext, unexpectedResultNext, countMismatchNext, eccSeenNext;

  // Readiness is combinational and forced low while rst is asserted.
  always_comb begin
    batchReqReady = 1'b0;
    botInReady    = 1'b0;
    if (!rst && state == IDLE) begin
      batchReqReady = !fifoFull;
    end else if (!rst && state == FEED) begin
      botInReady = !slowDownInput;
    end else begin
      batchReqReady = 1'b0;
      botInReady    = 1'b0;
    end
  end

  assign reqAccept    = batchReqValid && batchReqReady;
  assign zeroReq      = reqAccept && (batchReqBotCount == '0);
  assign pushReq      = reqAccept && (batchReqBotCount != '0);
  assign transfer     = botInValid && botInReady;
  assign lastTransfer = transfer && (remaining == COUNT_WIDTH'(1));

  // Next-state selection.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = pushReq ? FEED : IDLE;
      FEED:    nextState = lastTransfer ? IDLE : FEED;
      default: nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Bots left in the current batch; the nonzero guard keeps it from wrapping.
  always_ff @(posedge clk) begin
    if (rst)                                  remaining <= '0;
    else if (pushReq)                         remaining <= batchReqBotCount;
    else if (transfer && remaining != '0)     remaining <= remaining - 1'b1;
    else                                      remaining <= remaining;
  end

  // Registered pipeline-side outputs, one cycle behind the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      isBotValid     <= 1'b0;
      bot            <= '0;
      lastBotOfBatch <= 1'b0;
    end else begin
      isBotValid     <= transfer;
      lastBotOfBatch <= lastTransfer;
      if (transfer) bot <= botIn;
    end
  end

  expected_count_fifo #(
    .WIDTH (COUNT_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) uExpectedCounts (
    .clk       (clk),
    .rst       (rst),
    .push      (pushReq),
    .pushData  (batchReqBotCount),
    .pop       (resultPop),
    .head      (fifoHead),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .occupancy (outstanding)
  );

  assign resultPop    = pipeResultsValid && !fifoEmpty;
  assign headMismatch = (fifoHead != pipePcoeffCount);

  // Result strobe; a result with nothing outstanding always counts as a mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      resultValid    <= 1'b0;
      resultSum      <= '0;
      resultMismatch <= 1'b0;
    end else begin
      resultValid    <= pipeResultsValid;
      resultMismatch <= pipeResultsValid && (fifoEmpty || headMismatch);
      if (pipeResultsValid) resultSum <= pipePcoeffSum;
    end
  end

  assign illegalCountNext     = illegalCount     || zeroReq;
  assign unexpectedResultNext = unexpectedResult || (pipeResultsValid && fifoEmpty);
  assign countMismatchNext    = countMismatch    || (resultPop && headMismatch);
  assign eccSeenNext          = eccSeen          || pipeEccStatus;

  // Sticky error flags; errorSticky rises in the same cycle as the flag that caused it.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegalCount     <= 1'b0;
      unexpectedResult <= 1'b0;
      countMismatch    <= 1'b0;
      eccSeen          <= 1'b0;
      errorSticky      <= 1'b0;
    end else begin
      illegalCount     <= illegalCountNext;
      unexpectedResult <= unexpectedResultNext;
      countMismatch    <= countMismatchNext;
      eccSeen          <= eccSeenNext;
      errorSticky      <= illegalCountNext || unexpectedResultNext ||
                          countMismatchNext || eccSeenNext;
    end
  end

`ifdef BATCH_FEED_PROFILE_EN
  // Saturating profiling counters for backpressure and starvation while feeding.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCycles  <= 32'd0;
      starveCycles <= 32'd0;
    end else begin
      if (state == FEED && botInValid && slowDownInput) stallCycles <= satInc32(stallCycles);
      if (state == FEED && !botInValid)                 starveCycles <= satInc32(starveCycles);
    end
  end
`else
  assign stallCycles  = 32'd0;
  assign starveCycles = 32'd0;
`endif

endmodule
